// File: rtl/conv_stream_feeder_if.sv
// ---------------------------------------------------------------------------
// conv_stream_feeder_if
// Stream bundle between the frame feeder and the convolver.
//   x stream (feeder -> convolver): m_data_out_x, m_valid_x, m_ready_x
//   y stream (convolver -> feeder): s_data_in_y, s_valid_y, s_ready_y
// Modports:
//   master : feeder side (drives x data/valid and y ready)
//   slave  : convolver side (drives x ready and y data/valid)
// ---------------------------------------------------------------------------
interface conv_stream_feeder_if #(
    parameter int WIDTH = 16
);
    logic        [WIDTH-1:0] m_data_out_x;
    logic                    m_valid_x;
    logic                    m_ready_x;
    logic signed [WIDTH-1:0] s_data_in_y;
    logic                    s_valid_y;
    logic                    s_ready_y;

    modport master (
        output m_data_out_x,
        output m_valid_x,
        input  m_ready_x,
        input  s_data_in_y,
        input  s_valid_y,
        output s_ready_y
    );

    modport slave (
        input  m_data_out_x,
        input  m_valid_x,
        output m_ready_x,
        output s_data_in_y,
        output s_valid_y,
        input  s_ready_y
    );
endinterface

// File: rtl/conv_stream_feeder.sv
// ---------------------------------------------------------------------------
// conv_stream_feeder
// Frame-based feeder for a streaming convolver. The host fills an x-buffer,
// pulses start, and the block streams LENX x samples out while collecting
// LENY y samples back into a y-buffer the host can read.
// Ports:
//   clk           : clock, all state changes on the rising edge
//   reset         : asynchronous active-low reset
//   host_wr_en    : x-buffer write strobe (honoured in IDLE only)
//   host_wr_addr  : x-buffer write index
//   host_wr_data  : x-buffer write data
//   start         : begin a frame (sampled in IDLE only)
//   busy          : high while a frame is in RUN or DONE
//   strm          : x/y stream bundle, feeder side
//   host_rd_addr  : y-buffer read index
//   host_rd_data  : y-buffer read data, one cycle latency
//   frame_done    : one-cycle pulse at the end of a frame
//   y_count       : y samples accepted in the current / last frame
// ---------------------------------------------------------------------------
module conv_stream_feeder #(
    parameter int WIDTH = 16,
    parameter int LENX  = 64,
    parameter int LENY  = 32,
    parameter int ADDRX = 6,
    parameter int ADDRY = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               host_wr_en,
    input  logic [ADDRX-1:0]   host_wr_addr,
    input  logic [WIDTH-1:0]   host_wr_data,
    input  logic               start,
    output logic               busy,
    conv_stream_feeder_if.master strm,
    input  logic [ADDRY-1:0]   host_rd_addr,
    output logic [WIDTH-1:0]   host_rd_data,
    output logic               frame_done,
    output logic [ADDRY:0]     y_count
);

    // Indices are one bit wider than the buffer address so they can reach
    // LENX / LENY exactly and serve as "frame complete" markers.
    localparam int TXW = ADDRX + 1;
    localparam int RXW = ADDRY + 1;
    localparam logic [TXW-1:0] TX_LEN = TXW'(LENX);
    localparam logic [RXW-1:0] RX_LEN = RXW'(LENY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [TXW-1:0] tx_idx;
    logic [RXW-1:0] rx_idx;

    logic        [WIDTH-1:0] xbuf [2**ADDRX];
    logic signed [WIDTH-1:0] ybuf [2**ADDRY];

    logic x_fire;
    logic y_fire;

    // Stream controls depend only on registered state, so valid cannot be
    // withdrawn while the convolver stalls, and reset clears them at once.
    assign strm.m_valid_x    = (state == RUN) && (tx_idx < TX_LEN);
    assign strm.s_ready_y    = (state == RUN) && (rx_idx < RX_LEN);
    assign strm.m_data_out_x = xbuf[tx_idx[ADDRX-1:0]];

    assign x_fire = strm.m_valid_x && strm.m_ready_x;
    assign y_fire = strm.s_valid_y && strm.s_ready_y;

    assign busy       = (state != IDLE);
    assign frame_done = (state == DONE);
    assign y_count    = rx_idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if ((tx_idx == TX_LEN) && (rx_idx == RX_LEN)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Frame indices: cleared on start, advanced per completed transfer.
    // rx_idx doubles as y_count, so it is left alone outside a frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_idx <= '0;
            rx_idx <= '0;
        end else if ((state == IDLE) && start) begin
            tx_idx <= '0;
            rx_idx <= '0;
        end else begin
            if (x_fire) begin
                tx_idx <= tx_idx + TXW'(1);
            end
            if (y_fire) begin
                rx_idx <= rx_idx + RXW'(1);
            end
        end
    end

    // Buffer storage carries no reset; host writes are locked out while a
    // frame is in flight so the streamed data cannot change underneath it.
    always_ff @(posedge clk) begin
        if ((state == IDLE) && host_wr_en) begin
            xbuf[host_wr_addr] <= host_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (y_fire) begin
            ybuf[rx_idx[ADDRY-1:0]] <= strm.s_data_in_y;
        end
    end

    // Registered host read; a same-cycle y write is seen one cycle later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            host_rd_data <= '0;
        end else begin
            host_rd_data <= ybuf[host_rd_addr];
        end
    end

endmodule

// File: tb/tb_conv_stream_feeder.sv
// ---------------------------------------------------------------------------
// tb_conv_stream_feeder
// Randomized self-checking bench for conv_stream_feeder. A frame-level model
// (expected x array, captured y sequence, transfer counts) predicts every
// observable output each cycle.
// ---------------------------------------------------------------------------
module tb_conv_stream_feeder;
    localparam int WIDTH = 16;
    localparam int LENX  = 64;
    localparam int LENY  = 32;
    localparam int ADDRX = 6;
    localparam int ADDRY = 5;

    logic             clk;
    logic             reset;
    logic             host_wr_en;
    logic [ADDRX-1:0] host_wr_addr;
    logic [WIDTH-1:0] host_wr_data;
    logic             start;
    logic             busy;
    logic [ADDRY-1:0] host_rd_addr;
    logic [WIDTH-1:0] host_rd_data;
    logic             frame_done;
    logic [ADDRY:0]   y_count;

    conv_stream_feeder_if #(.WIDTH(WIDTH)) strm ();

    conv_stream_feeder #(
        .WIDTH(WIDTH), .LENX(LENX), .LENY(LENY), .ADDRX(ADDRX), .ADDRY(ADDRY)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .host_wr_en   (host_wr_en),
        .host_wr_addr (host_wr_addr),
        .host_wr_data (host_wr_data),
        .start        (start),
        .busy         (busy),
        .strm         (strm),
        .host_rd_addr (host_rd_addr),
        .host_rd_data (host_rd_data),
        .frame_done   (frame_done),
        .y_count      (y_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [WIDTH-1:0] xm   [LENX];
    logic [WIDTH-1:0] yexp [LENY];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_x(input bit ramp);
        for (int k = 0; k < LENX; k++) begin
            @(negedge clk);
            host_wr_en   = 1'b1;
            host_wr_addr = ADDRX'(k);
            host_wr_data = ramp ? WIDTH'(k) : WIDTH'($urandom);
            xm[k]        = host_wr_data;
        end
        @(negedge clk);
        host_wr_en = 1'b0;
    endtask

    task automatic read_y();
        for (int i = 0; i < LENY; i++) begin
            @(negedge clk);
            host_rd_addr = ADDRY'(i);
            @(negedge clk);
            check("ybuf", 32'(host_rd_data), 32'(yexp[i]));
        end
    endtask

    // One frame: random ready/valid, per-cycle prediction of every output.
    // after_full counts cycles since both transfer counts reached their end.
    task automatic run_frame(input int rdy_pct, input int yv_pct, input int stall_at,
                             input bit bogus_wr, input bit b2b, input bit skip_start,
                             input int abort_at);
        int tc, rc, after_full, stall_left;
        bit stall_done;
        tc = 0; rc = 0; after_full = -1; stall_left = 0; stall_done = 0;
        if (!skip_start) begin
            @(negedge clk);
            start = 1'b1;
            strm.m_ready_x = 1'b0;
            strm.s_valid_y = 1'b0;
        end
        for (int cyc = 0; cyc < 3000 && after_full < 3; cyc++) begin
            @(negedge clk);
            start        = 1'b0;
            host_wr_en   = bogus_wr && (cyc == 3);
            host_wr_addr = ADDRX'(5);
            host_wr_data = 16'hBEEF;
            if (stall_at >= 0 && !stall_done && tc == stall_at) begin
                stall_left = 5;
                stall_done = 1'b1;
            end
            strm.m_ready_x   = (stall_left == 0) && ($urandom_range(99) < rdy_pct);
            strm.s_valid_y   = (rc >= LENY) || ($urandom_range(99) < yv_pct);
            strm.s_data_in_y = WIDTH'($urandom);
            if (after_full >= 0) after_full++;
            if (b2b && after_full == 3) start = 1'b1;
            #1;
            check("frame_done", 32'(frame_done), 32'(after_full == 2));
            check("busy", 32'(busy), 32'(after_full < 3));
            check("m_valid_x", 32'(strm.m_valid_x), 32'(tc < LENX));
            check("s_ready_y", 32'(strm.s_ready_y), 32'(rc < LENY));
            check("y_count", 32'(y_count), rc);
            if (stall_left > 0) begin
                check("stall_data", 32'(strm.m_data_out_x), 32'(xm[stall_at]));
                stall_left--;
            end
            if (abort_at >= 0 && tc == abort_at) begin
                #1 reset = 1'b0;
                #1;
                check("rst_busy", 32'(busy), 0);
                check("rst_valid", 32'(strm.m_valid_x), 0);
                check("rst_ready", 32'(strm.s_ready_y), 0);
                check("rst_done", 32'(frame_done), 0);
                check("rst_ycount", 32'(y_count), 0);
                check("rst_rddata", 32'(host_rd_data), 0);
                @(negedge clk);
                reset = 1'b1;
                strm.m_ready_x = 1'b0;
                strm.s_valid_y = 1'b0;
                host_wr_en = 1'b0;
                return;
            end
            if (tc < LENX && strm.m_ready_x) begin
                check("x_beat", 32'(strm.m_data_out_x), 32'(xm[tc]));
                tc++;
            end
            if (rc < LENY && strm.s_valid_y) begin
                yexp[rc] = strm.s_data_in_y;
                rc++;
            end
            if (after_full < 0 && tc == LENX && rc == LENY) after_full = 0;
        end
        if (after_full < 3) check("frame_timeout", 0, 1);
        strm.m_ready_x = 1'b0;
        strm.s_valid_y = 1'b0;
        host_wr_en = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        host_wr_en = 1'b0;
        host_wr_addr = '0;
        host_wr_data = '0;
        start = 1'b0;
        host_rd_addr = '0;
        strm.m_ready_x = 1'b0;
        strm.s_valid_y = 1'b0;
        strm.s_data_in_y = '0;
        repeat (3) @(negedge clk);
        check("init_busy", 32'(busy), 0);
        check("init_valid", 32'(strm.m_valid_x), 0);
        check("init_ready", 32'(strm.s_ready_y), 0);
        check("init_done", 32'(frame_done), 0);
        check("init_ycount", 32'(y_count), 0);
        check("init_rddata", 32'(host_rd_data), 0);
        reset = 1'b1;

        // Ramp data, convolver always ready.
        load_x(1'b1);
        run_frame(100, 50, -1, 1'b0, 1'b0, 1'b0, -1);
        read_y();

        // Random data with a 5-cycle stall at index 10 and a locked-out
        // host write, then a back-to-back frame on the same x contents.
        load_x(1'b0);
        run_frame(50, 50, 10, 1'b1, 1'b1, 1'b0, -1);
        run_frame(50, 50, -1, 1'b0, 1'b0, 1'b1, -1);
        read_y();

        // Abort mid-frame, then a clean restart from index 0.
        run_frame(50, 50, -1, 1'b0, 1'b0, 1'b0, 20);
        run_frame(70, 30, -1, 1'b0, 1'b0, 1'b0, -1);
        read_y();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
